touch_filter: RTL and testbench
===============================

// Module: touch_filter
// PURPOSE
//  Debounces, jitter-checks and averages raw point reports from the touch-panel reader, producing
//  the stable 32-bit touch_data word consumed by state_control (area_judge). Sits directly upstream
//  of state_control. touch_data is 32'h0 when no press is confirmed and {x,y} while a press is held.
// PARAMETERS
//  DEBOUNCE_N   4        consecutive in-window touch samples to confirm a press (power of 2, >=2)
//  RELEASE_N    3        consecutive no-touch samples to confirm release (>=1)
//  JITTER_MAX   8        max |x-x0| and |y-y0| against the first sample of the debounce window
//  TIMEOUT_CYC  1000000  clk cycles with no raw_valid before forced return to IDLE
// PORTS
//  clk          in   1   system clock
//  rstn         in   1   synchronous active-low reset
//  raw_valid    in   1   one-cycle strobe: new report from the panel reader
//  raw_touch    in   1   report says a finger is present (qualified by raw_valid)
//  raw_x        in   16  report X coordinate (qualified by raw_valid)
//  raw_y        in   16  report Y coordinate (qualified by raw_valid)
//  touch_data   out  32  {x[15:0], y[15:0]} of the confirmed press; 32'h0 = no touch
//  touch_pulse  out  1   one-cycle strobe when a press is confirmed
// BEHAVIOUR
//  - One clock, synchronous active-low reset: state=IDLE, touch_data=0, touch_pulse=0, all counters
//    and accumulators 0. Reset wins over any concurrent input.
//  - All outputs registered; each update appears in the cycle after the edge sampling the strobe.
//  - FSM states: IDLE, DEBOUNCE, PRESSED.
//  - IDLE: raw_valid&raw_touch -> latch x0/y0, sum_x=raw_x, sum_y=raw_y, cnt=1, go DEBOUNCE.
//    raw_valid&!raw_touch ignored.
//  - DEBOUNCE, on raw_valid: !raw_touch, or |raw_x-x0|>JITTER_MAX, or |raw_y-y0|>JITTER_MAX -> IDLE,
//    accumulators cleared, no pulse. Otherwise accumulate and cnt++. When cnt reaches DEBOUNCE_N:
//    go PRESSED, touch_data={sum_x>>log2(N), sum_y>>log2(N)}, touch_pulse=1 for exactly one cycle.
//  - Averaging: sums are 16+log2(DEBOUNCE_N) bits, never overflow; truncating shift (floor).
//    Each averaged axis equal to 0 is output as 1, so a valid press never encodes as 32'h0.
//  - Differences are computed unsigned as max-min; no signed arithmetic.
//  - PRESSED: touch_data held constant (coordinate drift ignored). raw_valid&!raw_touch -> rel_cnt++;
//    raw_valid&raw_touch -> rel_cnt=0. When rel_cnt reaches RELEASE_N -> IDLE, touch_data=0.
//    A new press needs a full release and a fresh debounce; no auto-repeat.
//  - Timeout: idle counter cleared on every raw_valid, increments otherwise, saturates. In DEBOUNCE or
//    PRESSED, reaching TIMEOUT_CYC -> IDLE, touch_data=0, accumulators cleared. If raw_valid
//    coincides with the expiry cycle, raw_valid is processed and the timeout is discarded.
//  - touch_pulse is never asserted outside the DEBOUNCE->PRESSED transition. touch_data changes only
//    on entry to or exit from PRESSED.
// STRUCTURE
//  - Shared package touch_pkg: FSM state enum (IDLE/DEBOUNCE/PRESSED), TOUCH_NONE=32'h0, and the
//    {x,y} field slice positions, which are shared with area_judge.
//  - One sub-module: touch_accum. It holds x0/y0, the running sums, the jitter compare and the
//    averaged result. The FSM, release counter and timeout counter stay in touch_filter.
// TESTING
//  1. Reset held 3 cycles with raw_valid toggling -> touch_data=0, touch_pulse=0, no state change.
//  2. Four touch samples x=100,102,98,100 and y=200,201,199,200 -> touch_data=32'h006400C8, one pulse
//     cycle after 4th strobe.
//  3. 3rd sample x=109 (first sample x=100) -> back to IDLE, no pulse. Four clean samples follow ->
//     single pulse.
//  4. In PRESSED, send release,release,touch,release,release,release -> touch_data stays until the
//     3rd consecutive release, then 0 next cycle.
//  5. In PRESSED, stop raw_valid (TIMEOUT_CYC=50 in bench) -> touch_data=0 after 50 cycles. Repeat
//     with raw_valid on the expiry cycle -> remains PRESSED.
//  6. rstn low mid-DEBOUNCE (after 2 samples), release it, send 2 samples -> no pulse. Average of
//     x=0 samples -> x field=1.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared definitions for the touch filter and its consumers (area_judge).
package touch_pkg;

    // Filter FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } touch_state_e;

    // touch_data value meaning "no confirmed press"
    localparam logic [31:0] TOUCH_NONE = 32'h0000_0000;

    // {x,y} field positions inside touch_data, also used by area_judge
    localparam int COORD_W  = 16;
    localparam int TD_X_MSB = 31;
    localparam int TD_X_LSB = 16;
    localparam int TD_Y_MSB = 15;
    localparam int TD_Y_LSB = 0;

    // Unsigned distance between two coordinates, computed as max - min
    function automatic logic [COORD_W-1:0] coord_dist(input logic [COORD_W-1:0] a,
                                                      input logic [COORD_W-1:0] b);
        if (a >= b) begin
            coord_dist = a - b;
        end else begin
            coord_dist = b - a;
        end
    endfunction

    // A confirmed axis value of zero is reported as one, so a press never encodes as TOUCH_NONE
    function automatic logic [COORD_W-1:0] nonzero_coord(input logic [COORD_W-1:0] c);
        if (c == 16'd0) begin
            nonzero_coord = 16'd1;
        end else begin
            nonzero_coord = c;
        end
    endfunction

    // Build a touch_data word from its two axes
    function automatic logic [31:0] pack_touch(input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y);
        logic [31:0] w;
        w                     = TOUCH_NONE;
        w[TD_X_MSB:TD_X_LSB]  = x;
        w[TD_Y_MSB:TD_Y_LSB]  = y;
        pack_touch            = w;
    endfunction

endpackage

// File: rtl/touch_accum.sv
// Debounce-window datapath: first-sample anchor, running sums, jitter window and average.
// The window test and the average both look at the sample currently on the inputs, so the
// FSM can decide and publish a result at the same edge that consumes the sample.
module touch_accum
    import touch_pkg::*;
#(
    parameter int DEBOUNCE_N = 4,
    parameter int JITTER_MAX = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,     // first sample of a window: anchor and seed sums
    input  logic               accum_i,     // further in-window sample: add to sums
    input  logic               clear_i,     // abandon or finish the window
    input  logic [COORD_W-1:0] raw_x_i,
    input  logic [COORD_W-1:0] raw_y_i,
    output logic               in_window_o, // current sample lies within the jitter window
    output logic [COORD_W-1:0] avg_x_o,     // average including the current sample
    output logic [COORD_W-1:0] avg_y_o
);

    localparam int LOG2N = $clog2(DEBOUNCE_N);
    localparam int SUM_W = COORD_W + LOG2N;
    localparam logic [COORD_W-1:0] JIT_LIM = COORD_W'(JITTER_MAX);

    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [SUM_W-1:0]   sum_x_nxt, sum_y_nxt;

    // Window test against the anchor and sums/average that include the current sample
    always_comb begin
        sum_x_nxt   = sum_x_q + SUM_W'(raw_x_i);
        sum_y_nxt   = sum_y_q + SUM_W'(raw_y_i);
        in_window_o = (coord_dist(raw_x_i, x0_q) <= JIT_LIM) &&
                      (coord_dist(raw_y_i, y0_q) <= JIT_LIM);
        // Dropping the low LOG2N bits is a floor divide by DEBOUNCE_N
        avg_x_o     = nonzero_coord(sum_x_nxt[SUM_W-1:LOG2N]);
        avg_y_o     = nonzero_coord(sum_y_nxt[SUM_W-1:LOG2N]);
    end

    // Next-state for anchor and sums: clear beats start beats accumulate
    always_comb begin
        x0_d    = x0_q;
        y0_d    = y0_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        if (clear_i) begin
            x0_d    = 16'd0;
            y0_d    = 16'd0;
            sum_x_d = {SUM_W{1'b0}};
            sum_y_d = {SUM_W{1'b0}};
        end else if (start_i) begin
            x0_d    = raw_x_i;
            y0_d    = raw_y_i;
            sum_x_d = SUM_W'(raw_x_i);
            sum_y_d = SUM_W'(raw_y_i);
        end else if (accum_i) begin
            sum_x_d = sum_x_nxt;
            sum_y_d = sum_y_nxt;
        end else begin
            sum_x_d = sum_x_q;
            sum_y_d = sum_y_q;
        end
    end

    // Anchor and sum registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x0_q    <= 16'd0;
            y0_q    <= 16'd0;
            sum_x_q <= {SUM_W{1'b0}};
            sum_y_q <= {SUM_W{1'b0}};
        end else begin
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
        end
    end

endmodule

// File: rtl/touch_filter.sv
// Touch report filter: debounces and jitter-checks raw panel reports, averages the
// debounce window and holds the confirmed {x,y} until release or report timeout.
module touch_filter
    import touch_pkg::*;
#(
    parameter int DEBOUNCE_N  = 4,
    parameter int RELEASE_N   = 3,
    parameter int JITTER_MAX  = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               raw_valid,
    input  logic               raw_touch,
    input  logic [COORD_W-1:0] raw_x,
    input  logic [COORD_W-1:0] raw_y,
    output logic [31:0]        touch_data,
    output logic               touch_pulse
);

    localparam int CNT_W  = $clog2(DEBOUNCE_N + 1);
    localparam int REL_W  = $clog2(RELEASE_N + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_N - 1);
    localparam logic [REL_W-1:0]  REL_LAST = REL_W'(RELEASE_N - 1);
    localparam logic [IDLE_W-1:0] TO_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [IDLE_W-1:0] TO_SAT   = IDLE_W'(TIMEOUT_CYC);

    touch_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [31:0]        touch_data_q, touch_data_d;
    logic               touch_pulse_q, touch_pulse_d;

    logic               acc_start_s, acc_accum_s, acc_clear_s;
    logic               in_window_s;
    logic [COORD_W-1:0] avg_x_s, avg_y_s;
    logic               timeout_hit_s;

    touch_accum #(
        .DEBOUNCE_N (DEBOUNCE_N),
        .JITTER_MAX (JITTER_MAX)
    ) u_accum (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (acc_start_s),
        .accum_i     (acc_accum_s),
        .clear_i     (acc_clear_s),
        .raw_x_i     (raw_x),
        .raw_y_i     (raw_y),
        .in_window_o (in_window_s),
        .avg_x_o     (avg_x_s),
        .avg_y_o     (avg_y_s)
    );

    // Report-gap counter: cleared by any report, otherwise counts up and saturates.
    // Expiry only fires on a cycle without a report, so a coinciding report always wins.
    always_comb begin
        if (raw_valid) begin
            idle_cnt_d = {IDLE_W{1'b0}};
        end else if (idle_cnt_q == TO_SAT) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        timeout_hit_s = !raw_valid && (idle_cnt_q >= TO_LAST);
    end

    // Press/release FSM with debounce and release counters
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rel_cnt_d     = rel_cnt_q;
        touch_data_d  = touch_data_q;
        touch_pulse_d = 1'b0;
        acc_start_s   = 1'b0;
        acc_accum_s   = 1'b0;
        acc_clear_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (raw_valid && raw_touch) begin
                    acc_start_s = 1'b1;
                    cnt_d       = CNT_W'(1);
                    state_d     = ST_DEBOUNCE;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (raw_valid) begin
                    if (!raw_touch || !in_window_s) begin
                        acc_clear_s = 1'b1;
                        cnt_d       = {CNT_W{1'b0}};
                        state_d     = ST_IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        // Window complete: publish the average of all samples including this one
                        acc_clear_s   = 1'b1;
                        cnt_d         = {CNT_W{1'b0}};
                        rel_cnt_d     = {REL_W{1'b0}};
                        touch_data_d  = pack_touch(avg_x_s, avg_y_s);
                        touch_pulse_d = 1'b1;
                        state_d       = ST_PRESSED;
                    end else begin
                        acc_accum_s = 1'b1;
                        cnt_d       = cnt_q + CNT_W'(1);
                    end
                end else if (timeout_hit_s) begin
                    acc_clear_s = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DEBOUNCE;
                end
            end
            ST_PRESSED: begin
                // Coordinates reported while held are ignored; only touch/no-touch matters
                if (raw_valid) begin
                    if (raw_touch) begin
                        rel_cnt_d = {REL_W{1'b0}};
                    end else if (rel_cnt_q == REL_LAST) begin
                        rel_cnt_d    = {REL_W{1'b0}};
                        touch_data_d = TOUCH_NONE;
                        state_d      = ST_IDLE;
                    end else begin
                        rel_cnt_d = rel_cnt_q + REL_W'(1);
                    end
                end else if (timeout_hit_s) begin
                    rel_cnt_d    = {REL_W{1'b0}};
                    touch_data_d = TOUCH_NONE;
                    state_d      = ST_IDLE;
                end else begin
                    state_d      = ST_PRESSED;
                end
            end
            default: begin
                acc_clear_s  = 1'b1;
                cnt_d        = {CNT_W{1'b0}};
                rel_cnt_d    = {REL_W{1'b0}};
                touch_data_d = TOUCH_NONE;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            rel_cnt_q     <= {REL_W{1'b0}};
            idle_cnt_q    <= {IDLE_W{1'b0}};
            touch_data_q  <= TOUCH_NONE;
            touch_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rel_cnt_q     <= rel_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            touch_data_q  <= touch_data_d;
            touch_pulse_q <= touch_pulse_d;
        end
    end

    assign touch_data  = touch_data_q;
    assign touch_pulse = touch_pulse_q;

endmodule

// File: tb/tb_touch_filter.sv
// Self-checking bench for touch_filter: directed scenarios followed by randomized
// report streams, all compared each cycle against a sample-list reference model.
module tb_touch_filter;

    localparam int DEB_N = 4;
    localparam int REL_N = 3;
    localparam int JIT   = 8;
    localparam int TO    = 50;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        raw_valid = 1'b0;
    logic        raw_touch = 1'b0;
    logic [15:0] raw_x = 16'd0;
    logic [15:0] raw_y = 16'd0;
    logic [31:0] touch_data;
    logic        touch_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    // Reference model: mode 0 = no press, 1 = collecting samples, 2 = held
    int          m_mode = 0;
    int          qx[$];
    int          qy[$];
    int          m_rel = 0;
    int          m_cyc = 0;
    int          m_last_v = 0;
    logic [31:0] m_data = 32'h0;
    logic        m_pulse = 1'b0;

    touch_filter #(
        .DEBOUNCE_N  (DEB_N),
        .RELEASE_N   (REL_N),
        .JITTER_MAX  (JIT),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .raw_valid   (raw_valid),
        .raw_touch   (raw_touch),
        .raw_x       (raw_x),
        .raw_y       (raw_y),
        .touch_data  (touch_data),
        .touch_pulse (touch_pulse)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Apply one clock edge of stimulus to the reference model
    task automatic model_step(input logic rn, input logic v, input logic t, input int x, input int y);
        bit expired;
        int sx, sy, ax, ay;
        m_cyc++;
        m_pulse = 1'b0;
        if (!rn) begin
            m_mode = 0; qx.delete(); qy.delete(); m_rel = 0; m_data = 32'h0; m_last_v = m_cyc;
            return;
        end
        expired = !v && ((m_cyc - m_last_v) == TO);
        if (v) m_last_v = m_cyc;
        case (m_mode)
            0: begin
                if (v && t) begin
                    qx.delete(); qy.delete(); qx.push_back(x); qy.push_back(y); m_mode = 1;
                end
            end
            1: begin
                if (v) begin
                    if (!t || absd(x, qx[0]) > JIT || absd(y, qy[0]) > JIT) begin
                        m_mode = 0; qx.delete(); qy.delete();
                    end else begin
                        qx.push_back(x); qy.push_back(y);
                        if (qx.size() == DEB_N) begin
                            sx = 0; sy = 0;
                            foreach (qx[i]) begin sx += qx[i]; sy += qy[i]; end
                            ax = sx / DEB_N; ay = sy / DEB_N;
                            if (ax == 0) ax = 1;
                            if (ay == 0) ay = 1;
                            m_data = {16'(ax), 16'(ay)};
                            m_pulse = 1'b1; m_mode = 2; m_rel = 0;
                            qx.delete(); qy.delete();
                        end
                    end
                end else if (expired) begin
                    m_mode = 0; qx.delete(); qy.delete();
                end
            end
            2: begin
                if (v) begin
                    if (t) m_rel = 0;
                    else begin
                        m_rel++;
                        if (m_rel == REL_N) begin m_mode = 0; m_data = 32'h0; m_rel = 0; end
                    end
                end else if (expired) begin
                    m_mode = 0; m_data = 32'h0; m_rel = 0;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    // Drive one cycle, advance the model, then compare just after the edge
    task automatic cycle(input logic rn, input logic v, input logic t,
                         input logic [15:0] x, input logic [15:0] y);
        rstn = rn; raw_valid = v; raw_touch = t; raw_x = x; raw_y = y;
        @(posedge clk);
        model_step(rn, v, t, int'(x), int'(y));
        #1;
        check_eq("touch_data", touch_data, m_data);
        check_eq("touch_pulse", {31'd0, touch_pulse}, {31'd0, m_pulse});
        if (touch_pulse) pulse_cnt++;
    endtask

    task automatic sample(input logic [15:0] x, input logic [15:0] y);
        cycle(1'b1, 1'b1, 1'b1, x, y);
    endtask

    task automatic rel();
        cycle(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic press_100_200();
        sample(16'd100, 16'd200); sample(16'd100, 16'd200);
        sample(16'd100, 16'd200); sample(16'd100, 16'd200);
    endtask

    initial begin
        int gap, bx, by, xv, yv, r;
        logic v, t;

        // 1: reset held with reports toggling
        for (int i = 0; i < 3; i++) cycle(1'b0, (i % 2) == 0, 1'b1, 16'd100, 16'd200);
        check_eq("rst_data", touch_data, 32'h0);
        check_eq("rst_pulse", {31'd0, touch_pulse}, 32'd0);

        // 2: four jittery samples averaged
        pulse_cnt = 0;
        sample(16'd100, 16'd200); sample(16'd102, 16'd201); sample(16'd98, 16'd199);
        check_eq("t2_no_early_pulse", pulse_cnt, 32'd0);
        sample(16'd100, 16'd200);
        check_eq("t2_data", touch_data, 32'h0064_00C8);
        check_eq("t2_pulse", {31'd0, touch_pulse}, 32'd1);
        quiet(1);
        check_eq("t2_pulse_once", pulse_cnt, 32'd1);

        // 4: release counting with an interrupting touch
        rel(); rel(); sample(16'd500, 16'd500); rel(); rel();
        check_eq("t4_held", touch_data, 32'h0064_00C8);
        rel();
        check_eq("t4_released", touch_data, 32'h0);

        // 3: jitter violation aborts the window, then a clean window confirms
        pulse_cnt = 0;
        sample(16'd100, 16'd200); sample(16'd100, 16'd200); sample(16'd109, 16'd200);
        check_eq("t3_abort_no_pulse", pulse_cnt, 32'd0);
        sample(16'd100, 16'd200); sample(16'd101, 16'd201);
        sample(16'd99, 16'd199); sample(16'd100, 16'd200);
        check_eq("t3_single_pulse", pulse_cnt, 32'd1);
        check_eq("t3_data", touch_data, 32'h0064_00C8);
        rel(); rel(); rel();

        // 5: timeout while pressed, then a report landing on the expiry cycle
        press_100_200();
        quiet(TO - 1);
        check_eq("t5_before_expiry", touch_data, 32'h0064_00C8);
        quiet(1);
        check_eq("t5_expired", touch_data, 32'h0);
        press_100_200();
        quiet(TO - 1);
        sample(16'd100, 16'd200);
        check_eq("t5_report_on_expiry", touch_data, 32'h0064_00C8);
        quiet(5);
        check_eq("t5_still_pressed", touch_data, 32'h0064_00C8);
        rel(); rel(); rel();

        // 6: reset mid-window discards the partial window; zero average reported as 1
        pulse_cnt = 0;
        sample(16'd300, 16'd300); sample(16'd300, 16'd300);
        cycle(1'b0, 1'b1, 1'b1, 16'd300, 16'd300);
        sample(16'd300, 16'd300); sample(16'd300, 16'd300);
        check_eq("t6_no_pulse_after_rst", pulse_cnt, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        sample(16'd0, 16'd4); sample(16'd0, 16'd4); sample(16'd1, 16'd3); sample(16'd2, 16'd2);
        check_eq("t6_zero_axis", touch_data, {16'd1, 16'd3});
        rel(); rel(); rel();

        // Randomized report streams
        gap = 0; bx = 1000; by = 1000;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                bx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 65535));
                by = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 65535));
            end
            if (gap == 0 && $urandom_range(0, 99) == 0) gap = int'($urandom_range(40, 60));
            xv = bx + int'($urandom_range(0, 20)) - 10;
            yv = by + int'($urandom_range(0, 20)) - 10;
            if (xv < 0) xv = 0;
            if (xv > 65535) xv = 65535;
            if (yv < 0) yv = 0;
            if (yv > 65535) yv = 65535;
            r = int'($urandom_range(0, 999));
            if (gap > 0) begin
                gap--;
                v = 1'b0;
            end else begin
                v = ($urandom_range(0, 9) < 4);
            end
            t = ($urandom_range(0, 9) < 8);
            cycle(r >= 3, v, t, 16'(xv), 16'(yv));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
